gtp_comma_align: RTL and testbench

Receive-side word aligner for the 20-bit GTP interface running with the transceiver's internal comma aligner disabled. Searches the raw 20-bit `gtp_rxd` stream for K28.5 at any of 20 bit offsets, qualifies the alignment over several commas, and presents re-aligned 20-bit words with every comma in the low (earlier-in-time) symbol. Sits between the GTP receiver and the 20-to-10 gmii split, so that split's even/odd symbol selection is deterministic.

---
 rtl/gtp_align_pkg.sv | 25 ++
 rtl/comma_search.sv | 38 +++
 rtl/gtp_comma_align.sv | 178 +++++++++++++++++
 tb/tb_gtp_comma_align.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gtp_align_pkg.sv
// ============================================================================
// Module      : gtp_align_pkg
// Description : Shared constants for the GTP receive word aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gtp_align_pkg;

    localparam logic [9:0] COMMA_P = 10'b0101111100;
    localparam logic [9:0] COMMA_N = 10'b1010000011;

    localparam int OFF_W = 5;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == COMMA_P) || (sym == COMMA_N);
    endfunction

endpackage

`default_nettype wire

// File: rtl/comma_search.sv
// ============================================================================
// Module      : comma_search
// Description : Combinational K28.5 search over a two-word window; reports
//               whether any offset matches and the lowest matching offset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comma_search
    import gtp_align_pkg::*;
#(
    parameter int dw = 10
) (
    input  logic [4*dw-1:0]  window,
    output logic             hit,
    output logic [OFF_W-1:0] hit_off
);

    logic [2*dw-1:0] w_match;

    for (genvar k = 0; k < 2*dw; k++) begin : g_cmp
        assign w_match[k] = is_comma(window[k +: dw]);
    end

    // Scan downward so the lowest matching offset is the one that sticks.
    always_comb begin
        hit     = |w_match;
        hit_off = '0;
        for (int k = 2*dw-1; k >= 0; k--) begin
            if (w_match[k]) begin
                hit_off = OFF_W'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gtp_comma_align.sv
// ============================================================================
// Module      : gtp_comma_align
// Description : 20-bit GTP receive word aligner: hunts K28.5 at any bit
//               offset, qualifies it and outputs words with commas low.
//               Optional statistics counters: GTP_COMMA_ALIGN_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gtp_comma_align
    import gtp_align_pkg::*;
#(
    parameter int dw       = 10,
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 3
) (
    input  logic              gtp_rx_clk,
    input  logic              rst_n,
    input  logic [2*dw-1:0]   gtp_rxd,
    output logic [2*dw-1:0]   aligned_rxd,
    output logic              comma_det,
    output logic              locked,
    output logic [OFF_W-1:0]  offset,
`ifdef GTP_COMMA_ALIGN_STATS_EN
    output logic [15:0]       realign_cnt,
    output logic [15:0]       miss_cnt,
`endif
    output logic              realign
);

    localparam logic [3:0] c_good_max  = 4'(LOCK_CNT);
    localparam logic [3:0] c_good_last = 4'(LOCK_CNT - 1);
    localparam logic [3:0] c_miss_last = 4'(MISS_MAX - 1);

    logic [2*dw-1:0]  r_prev;
    logic [2*dw-1:0]  r_aligned;
    logic             r_comma_det;
    logic [4*dw-1:0]  w_win;
    logic [4*dw-1:0]  w_shifted;
    logic             w_hit;
    logic [OFF_W-1:0] w_hit_off;
    logic             w_same;

    logic [1:0]       r_state, w_state_nxt;
    logic [3:0]       r_good, w_good_nxt;
    logic [3:0]       r_miss, w_miss_nxt;
    logic [OFF_W-1:0] r_offset, w_offset_nxt;
    logic             r_realign, w_realign_nxt;

    assign w_win     = {gtp_rxd, r_prev};
    assign w_shifted = w_win >> r_offset;
    assign w_same    = (w_hit_off == r_offset);

    comma_search #(.dw(dw)) u_search (
        .window  (w_win),
        .hit     (w_hit),
        .hit_off (w_hit_off)
    );

    always_ff @(posedge gtp_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HUNT: begin
                if (w_hit) begin
                    w_state_nxt = (LOCK_CNT == 1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                if (w_hit && w_same && (r_good >= c_good_last)) begin
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (w_hit && !w_same && (r_miss >= c_miss_last)) begin
                    w_state_nxt = HUNT;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_comb begin
        locked        = (r_state == LOCKED);
        w_offset_nxt  = r_offset;
        w_good_nxt    = r_good;
        w_miss_nxt    = r_miss;
        w_realign_nxt = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_hit) begin
                    w_offset_nxt  = w_hit_off;
                    w_realign_nxt = 1'b1;
                    w_good_nxt    = 4'd1;
                    w_miss_nxt    = 4'd0;
                end
            end
            CHECK: begin
                if (w_hit && w_same) begin
                    w_good_nxt = (r_good >= c_good_max) ? r_good : r_good + 4'd1;
                end else if (w_hit) begin
                    w_offset_nxt  = w_hit_off;
                    w_realign_nxt = 1'b1;
                    w_good_nxt    = 4'd1;
                end
            end
            LOCKED: begin
                if (w_hit && w_same) begin
                    w_miss_nxt = 4'd0;
                end else if (w_hit) begin
                    // The final miss drops back to HUNT with a clean count.
                    w_miss_nxt = (r_miss >= c_miss_last) ? 4'd0 : r_miss + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge gtp_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev      <= '0;
            r_aligned   <= '0;
            r_comma_det <= 1'b0;
            r_offset    <= '0;
            r_good      <= 4'd0;
            r_miss      <= 4'd0;
            r_realign   <= 1'b0;
        end else begin
            r_prev      <= gtp_rxd;
            r_aligned   <= w_shifted[2*dw-1:0];
            r_comma_det <= is_comma(w_shifted[dw-1:0]);
            r_offset    <= w_offset_nxt;
            r_good      <= w_good_nxt;
            r_miss      <= w_miss_nxt;
            r_realign   <= w_realign_nxt;
        end
    end

    assign aligned_rxd = r_aligned;
    assign comma_det   = r_comma_det;
    assign offset      = r_offset;
    assign realign     = r_realign;

`ifdef GTP_COMMA_ALIGN_STATS_EN
    logic [15:0] r_realign_cnt;
    logic [15:0] r_miss_cnt;
    logic        w_miss_evt;

    assign w_miss_evt = (r_state == LOCKED) && w_hit && !w_same;

    always_ff @(posedge gtp_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_realign_cnt <= 16'd0;
            r_miss_cnt    <= 16'd0;
        end else begin
            if (r_realign && (r_realign_cnt != 16'hFFFF)) begin
                r_realign_cnt <= r_realign_cnt + 16'd1;
            end
            if (w_miss_evt && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign realign_cnt = r_realign_cnt;
    assign miss_cnt    = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gtp_comma_align.sv
// ============================================================================
// Module      : tb_gtp_comma_align
// Description : Self-checking bench for gtp_comma_align with a bit-window
//               reference model; honours GTP_COMMA_ALIGN_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gtp_comma_align;

    localparam logic [9:0]  K_P    = 10'b0101111100;
    localparam logic [9:0]  K_N    = 10'b1010000011;
    localparam logic [19:0] FILLER = 20'hAAAAA;
    localparam int          LOCKN  = 4;
    localparam int          MISSN  = 3;

    logic        gtp_rx_clk = 1'b0;
    logic        rst_n;
    logic [19:0] gtp_rxd;
    logic [19:0] aligned_rxd;
    logic        comma_det;
    logic        locked;
    logic [4:0]  offset;
    logic        realign;
`ifdef GTP_COMMA_ALIGN_STATS_EN
    logic [15:0] realign_cnt;
    logic [15:0] miss_cnt;
`endif

    gtp_comma_align #(.dw(10), .LOCK_CNT(LOCKN), .MISS_MAX(MISSN)) dut (
        .gtp_rx_clk  (gtp_rx_clk),
        .rst_n       (rst_n),
        .gtp_rxd     (gtp_rxd),
        .aligned_rxd (aligned_rxd),
        .comma_det   (comma_det),
        .locked      (locked),
        .offset      (offset),
`ifdef GTP_COMMA_ALIGN_STATS_EN
        .realign_cnt (realign_cnt),
        .miss_cnt    (miss_cnt),
`endif
        .realign     (realign)
    );

    always #5 gtp_rx_clk = ~gtp_rx_clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    // reference model: bit window plus a plain mode/offset/counter picture
    logic [19:0] m_prev;
    int          m_mode;   // 0 searching, 1 qualifying, 2 locked
    int          m_off, m_good, m_miss;
    logic [19:0] e_aligned;
    logic        e_det, e_realign;
    int          e_rcnt, e_mcnt;

    logic [19:0] wq[$];
    logic        h_locked[0:4095];
    logic        h_realign[0:4095];
    logic [4:0]  h_off[0:4095];
    logic [9:0]  h_low[0:4095];
    logic        h_det[0:4095];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_mode = 0; m_off = 0; m_good = 0; m_miss = 0;
        e_aligned = '0; e_det = 1'b0; e_realign = 1'b0; e_rcnt = 0; e_mcnt = 0;
    endtask

    task automatic model_edge(input logic [19:0] d);
        logic [39:0] win;
        logic [39:0] sh;
        logic [9:0]  s;
        int          k_hit;
        win   = {d, m_prev};
        k_hit = -1;
        for (int k = 0; k < 20; k++) begin
            s = win[k +: 10];
            if (k_hit < 0 && (s == K_P || s == K_N)) k_hit = k;
        end
        sh        = win >> m_off;
        e_aligned = sh[19:0];
        e_det     = (sh[9:0] == K_P) || (sh[9:0] == K_N);
        if (e_realign && e_rcnt < 65535) e_rcnt++;
        e_realign = 1'b0;
        if (k_hit >= 0) begin
            if (m_mode == 0 || (m_mode == 1 && k_hit != m_off)) begin
                m_off = k_hit; m_good = 1; e_realign = 1'b1;
                m_mode = (LOCKN == 1) ? 2 : 1;
            end else if (m_mode == 1) begin
                if (m_good < LOCKN) m_good++;
                if (m_good >= LOCKN) m_mode = 2;
            end else if (k_hit == m_off) begin
                m_miss = 0;
            end else begin
                m_miss++;
                if (e_mcnt < 65535) e_mcnt++;
                if (m_miss >= MISSN) begin m_mode = 0; m_miss = 0; end
            end
        end
        m_prev = d;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".aligned_rxd"}, 32'(aligned_rxd), 32'(e_aligned));
        chk({tag, ".comma_det"},   32'(comma_det),   32'(e_det));
        chk({tag, ".locked"},      32'(locked),      32'(m_mode == 2));
        chk({tag, ".offset"},      32'(offset),      32'(m_off));
        chk({tag, ".realign"},     32'(realign),     32'(e_realign));
`ifdef GTP_COMMA_ALIGN_STATS_EN
        chk({tag, ".realign_cnt"}, 32'(realign_cnt), 32'(e_rcnt));
        chk({tag, ".miss_cnt"},    32'(miss_cnt),    32'(e_mcnt));
`endif
    endtask

    task automatic cycle(input logic [19:0] d);
        gtp_rxd = d;
        @(posedge gtp_rx_clk);
        model_edge(d);
        #1;
        check_outputs("cyc");
        h_locked[cyc] = locked;  h_realign[cyc] = realign; h_off[cyc] = offset;
        h_low[cyc] = aligned_rxd[9:0]; h_det[cyc] = comma_det;
        cyc++;
    endtask

    task automatic fill(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(FILLER);
    endtask

    task automatic plant(input int idx, input int k, input logic [9:0] code);
        logic [39:0] w;
        w = {wq[idx], wq[idx-1]};
        w[k +: 10] = code;
        wq[idx]   = w[39:20];
        wq[idx-1] = w[19:0];
    endtask

    task automatic play(output int base);
        base = cyc;
        for (int i = 0; i < wq.size(); i++) cycle(wq[i]);
    endtask

    function automatic int count_realign(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(h_realign[i]);
        return n;
    endfunction

    function automatic int count_locked(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(h_locked[i]);
        return n;
    endfunction

    initial begin
        int b;
        int ko, kk;
        rst_n   = 1'b0;
        gtp_rxd = '0;
        model_reset();
        repeat (2) @(posedge gtp_rx_clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        // acquisition at offset 7, one comma every 4 words
        fill(20);
        plant(2, 7, K_P); plant(6, 7, K_P); plant(10, 7, K_P); plant(14, 7, K_P);
        play(b);
        chk("s1_realign_at_first", 32'(h_realign[b+2]), 1);
        chk("s1_offset_first", 32'(h_off[b+2]), 7);
        chk("s1_realign_count", count_realign(b, b+19), 1);
        chk("s1_not_locked_3rd", 32'(h_locked[b+10]), 0);
        chk("s1_locked_4th", 32'(h_locked[b+14]), 1);
        chk("s1_low_symbol", 32'(h_low[b+14]), 32'(K_P));
        chk("s1_comma_det", 32'(h_det[b+14]), 1);

        // two misses then a hit clears the miss count: four misses total stay locked
        fill(18);
        plant(2, 12, K_P); plant(5, 12, K_N); plant(8, 7, K_P);
        plant(10, 12, K_P); plant(13, 12, K_P); plant(15, 7, K_N);
        play(b);
        chk("s2_locked_all", count_locked(b, b+17), 18);
        chk("s2_no_realign", count_realign(b, b+17), 0);

        // three consecutive misses drop lock; next comma re-hunts
        fill(14);
        plant(2, 12, K_P); plant(5, 12, K_P); plant(8, 12, K_P); plant(11, 12, K_P);
        play(b);
        chk("s3_locked_2nd", 32'(h_locked[b+5]), 1);
        chk("s3_unlocked_3rd", 32'(h_locked[b+8]), 0);
        chk("s3_realign", 32'(h_realign[b+11]), 1);
        chk("s3_offset", 32'(h_off[b+11]), 12);
        chk("s3_realign_count", count_realign(b, b+13), 1);

        // restart inside CHECK: offset 3, then 15
        fill(10);
        plant(2, 3, K_P); plant(5, 15, K_N);
        play(b);
        chk("s4_offset3", 32'(h_off[b+2]), 3);
        chk("s4_offset15", 32'(h_off[b+5]), 15);
        chk("s4_realign15", 32'(h_realign[b+5]), 1);
        fill(14);
        plant(2, 15, K_P); plant(6, 15, K_P); plant(10, 15, K_P);
        play(b);
        chk("s4_not_locked_good3", 32'(h_locked[b+6]), 0);
        chk("s4_locked_good4", 32'(h_locked[b+10]), 1);

        // asynchronous reset mid-lock
        fill(3);
        play(b);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2 rst_n = 1'b1;

        // two commas in one window: lowest offset wins; full relock needed
        fill(16);
        plant(2, 2, K_P); plant(2, 12, K_N);
        plant(6, 2, K_N); plant(10, 2, K_P); plant(14, 2, K_P);
        play(b);
        chk("s5_offset_low", 32'(h_off[b+2]), 2);
        chk("s5_not_locked_3rd", 32'(h_locked[b+10]), 0);
        chk("s5_locked_4th", 32'(h_locked[b+14]), 1);

        // randomized traffic against the model
        for (int r = 0; r < 6; r++) begin
            wq.delete();
            for (int i = 0; i < 60; i++) wq.push_back(20'($urandom));
            ko = $urandom_range(0, 19);
            for (int i = 1; i < 60; i += 3) begin
                kk = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 19) : ko;
                plant(i, kk, $urandom_range(0, 1) ? K_P : K_N);
            end
            play(b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
